rr_priority_arbiter: RTL
========================

// Module: rr_priority_arbiter
//
// PURPOSE
//   Parametrised N-way arbiter. Successor to the 4-bit combinational priority circuit.
//   Takes N request lines and issues a registered one-hot grant plus a binary grant index.
//   The grant is held until the owner signals completion.
//   Two modes: fixed priority (highest index wins) or rotating round-robin.
//   Sits between N requesters and one shared resource.
//
// PARAMETERS
//   N     4   number of requesters, N >= 2
//   RR    1   1 = round-robin rotation, 0 = fixed priority (index N-1 highest)
//   ID_W  $clog2(N)   width of grant_id; derived, do not override
//
// PORTS
//   clk       in   1     rising-edge clock
//   reset     in   1     asynchronous, active-high reset
//   req       in   N     request vector, bit i = requester i
//   done      in   1     current owner releases the grant this cycle
//   grant     out  N     registered one-hot grant, all zero when idle
//   grant_id  out  ID_W  binary index of the grant bit, 0 when idle
//   busy      out  1     1 while a grant is held
//
// BEHAVIOUR
//   - Reset (async, immediate): grant=0, grant_id=0, busy=0, state=IDLE, ptr=0.
//   - All outputs are registered. No combinational path from req or done to any output.
//   - States:
//       IDLE : no owner.
//       GRANT: one owner, grant stable.
//   - Priority order, RR=1: ptr-1, ptr-2, ..., 0, N-1, ..., ptr (mod N).
//       ptr = index of the last completed grant.
//       ptr=0 at reset gives the fixed order N-1..0.
//   - Priority order, RR=0: always N-1 down to 0. ptr is unused.
//   - IDLE, req==0: stay in IDLE. done is ignored.
//   - IDLE, req!=0: arbitrate on the req sampled this edge.
//       Next cycle: grant=one-hot winner, grant_id=winner, busy=1, state=GRANT.
//       Latency from req to grant is 1 cycle.
//   - GRANT, done==0: grant, grant_id and busy hold.
//       Changes to req are ignored, including deassertion of the owner's own req.
//   - GRANT, done==1:
//       ptr <= owner index (RR=1 only).
//       Arbitrate on req sampled in the same cycle, using the updated order.
//       The owner's req still counts: lowest priority in RR=1, normal rank in RR=0.
//       If any req is set: next cycle carries the new grant. No idle gap; busy stays 1.
//       If no req is set: next cycle grant=0, grant_id=0, busy=0, state=IDLE.
//   - Exactly one grant bit is ever set. grant != 0 if and only if busy == 1.
//   - ptr wrap-around: when the owner is index 0, the next search starts at N-1.
//   - Reset asserted mid-grant: grant drops asynchronously and rotation history is lost.
//   - Non-power-of-two N is legal. grant_id never exceeds N-1.
//
// TESTING  (N=4)
//   1. Assert reset with req=1111 -> grant=0000, grant_id=0, busy=0; hold state after release.
//   2. RR=1, req=1111 held, done pulsed one cycle after each grant
//        -> grant sequence 1000, 0100, 0010, 0001, 1000, each with no idle cycle.
//   3. RR=0, same stimulus -> grant stays 1000 every round.
//   4. req=0101 in IDLE, then req=0000 while granted -> grant=0100 held until done.
//        Then busy=0 and grant=0000 on the next cycle.
//   5. done with req=0000 in IDLE -> no change.
//        Then with grant=0010 and req=0001, pulse done -> grant=0001 on the next cycle, busy stays 1.
//   6. Assert reset between clock edges while grant=0010 -> grant=0000 immediately.
//        Release, then req=1111 -> grant=1000 (ptr was reset).

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with registered one-hot grant, held until the owner signals done.
// RR=1 rotates priority past the last completed owner; RR=0 is fixed priority, with index N-1 highest.
module rr_priority_arbiter #(
  parameter int N    = 4,
  parameter int RR   = 1,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_grant;
  logic [ID_W-1:0] r_grant_id;
  logic            r_busy;
  logic [ID_W-1:0] r_ptr;

  logic            w_any;
  logic            w_release;
  logic            w_load;
  logic [ID_W-1:0] w_base;
  logic [ID_W-1:0] w_cand;
  logic [ID_W-1:0] w_win_id;
  logic [N-1:0]    w_grant_nxt;
  logic [ID_W-1:0] w_id_nxt;
  logic            w_busy_nxt;

  assign w_any     = |req;
  assign w_release = (r_state == GRANT) && done;
  assign w_load    = ((r_state == IDLE) && w_any) || w_release;

  // On release the order is computed from the departing owner, not the stale ptr.
  always_comb begin
    w_base = '0;
    if (RR != 0) begin
      w_base = w_release ? r_grant_id : r_ptr;
    end
  end

  // Candidates are visited lowest priority first, so the last hit is the winner.
  always_comb begin
    w_win_id = '0;
    w_cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = ID_W'((32'(w_base) + N + k) % N);
      if (req[w_cand]) begin
        w_win_id = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_id_nxt;
      r_busy     <= w_busy_nxt;
      if ((RR != 0) && w_release) begin
        r_ptr <= r_grant_id;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = GRANT;
      GRANT:   if (done && !w_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt = r_grant;
    w_id_nxt    = r_grant_id;
    w_busy_nxt  = r_busy;
    if (w_load) begin
      w_grant_nxt = '0;
      w_id_nxt    = '0;
      w_busy_nxt  = w_any;
      if (w_any) begin
        w_grant_nxt[w_win_id] = 1'b1;
        w_id_nxt              = w_win_id;
      end
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule
